// File: rtl/cmd_ctrl_multi_pkg.sv
// ---------------------------------------------------------------------------
// ctrl_pkg : shared definitions for the cmd_ctrl_multi byte-command controller.
//   - command byte codes received from the UART
//   - response byte codes returned to the UART
//   - controller state enumeration
//   - 7-segment (active-low, gfedcba) digit lookup
// ---------------------------------------------------------------------------
package ctrl_pkg;

   // Command bytes
   localparam logic [7:0] CMD_DAC_RST = 8'h72;
   localparam logic [7:0] CMD_DAC_INC = 8'h74;
   localparam logic [7:0] CMD_DAC_DEC = 8'h65;
   localparam logic [7:0] CMD_POT_RST = 8'h66;
   localparam logic [7:0] CMD_POT_INC = 8'h67;
   localparam logic [7:0] CMD_POT_DEC = 8'h64;
   localparam logic [7:0] CMD_SEL_INC = 8'h61;
   localparam logic [7:0] CMD_SEL_DEC = 8'h71;
   localparam logic [7:0] CMD_RB_POT  = 8'h76;
   localparam logic [7:0] CMD_RB_DAC  = 8'h77;

   // Response bytes
   localparam logic [7:0] RSP_RESET   = 8'h40;
   localparam logic [7:0] RSP_DAC_RST = 8'h01;
   localparam logic [7:0] RSP_DAC_INC = 8'h03;
   localparam logic [7:0] RSP_DAC_DEC = 8'h04;
   localparam logic [7:0] RSP_POT_RST = 8'h05;
   localparam logic [7:0] RSP_POT_INC = 8'h06;
   localparam logic [7:0] RSP_POT_DEC = 8'h07;
   localparam logic [7:0] RSP_SEL_INC = 8'h08;
   localparam logic [7:0] RSP_SEL_DEC = 8'h09;
   localparam logic [7:0] RSP_NAK     = 8'h3F;
   localparam logic [7:0] RSP_SAT_BIT = 8'h80;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      DAC_FRAME = 2'd1,
      POT_FRAME = 2'd2
   } ctrl_state_e;

   // Active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}; blank for >9.
   function automatic logic [6:0] seg7_digit(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b1000000;
         4'd1:    s = 7'b1111001;
         4'd2:    s = 7'b0100100;
         4'd3:    s = 7'b0110000;
         4'd4:    s = 7'b0011001;
         4'd5:    s = 7'b0010010;
         4'd6:    s = 7'b0000010;
         4'd7:    s = 7'b1111000;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0010000;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/cmd_ctrl_multi_if.sv
// ---------------------------------------------------------------------------
// cmd_ctrl_multi_if : bus bundle between the command controller and its
// surroundings (UART rx/tx side, DAC, pot chain, display).
//
// Handshake: a command byte transfers on a rising clk edge where
// rx_valid && rx_ready are both high. rx_valid presented while rx_ready is
// low is not held off -- the byte is simply ignored and never answered.
// resp_valid is a single-cycle strobe qualifying resp_data; there is no
// back-pressure on the response side.
//
// Signals:
//   rx_data/rx_valid  -> command byte and its strobe (master drives)
//   rx_ready          <- controller idle and able to accept
//   resp_data/valid   <- response byte and one-cycle strobe
//   dac_word/dac_cs_n <- {control nibble, DAC code}, active-low DAC select
//   pot_sel/pot_word  <- selected pot channel and its code
//   pot_cs_n          <- active-low pot-chain select
//   seg               <- active-low 7-segment digit of pot_sel
//   state             <- controller state, for observation only
// ---------------------------------------------------------------------------
interface cmd_ctrl_multi_if
   import ctrl_pkg::*;
#(
   parameter int SEL_W    = 2,
   parameter int DAC_BITS = 12,
   parameter int POT_BITS = 8
) ();

   logic [7:0]          rx_data;
   logic                rx_valid;
   logic                rx_ready;
   logic [7:0]          resp_data;
   logic                resp_valid;
   logic [DAC_BITS+3:0] dac_word;
   logic                dac_cs_n;
   logic [SEL_W-1:0]    pot_sel;
   logic [POT_BITS-1:0] pot_word;
   logic                pot_cs_n;
   logic [6:0]          seg;
   ctrl_state_e         state;

   modport slave (
      input  rx_data, rx_valid,
      output rx_ready, resp_data, resp_valid, dac_word, dac_cs_n,
             pot_sel, pot_word, pot_cs_n, seg, state
   );

   modport master (
      output rx_data, rx_valid,
      input  rx_ready, resp_data, resp_valid, dac_word, dac_cs_n,
             pot_sel, pot_word, pot_cs_n, seg, state
   );

endinterface

// File: rtl/cmd_ctrl_multi_cs_pulse_gen.sv
// ---------------------------------------------------------------------------
// cs_pulse_gen : chip-select window generator.
// A start strobe sampled on edge k drives cs_n low from cycle k+1 for exactly
// CYCLES cycles. done is high during the last low cycle so the owner can
// leave its frame state on the same edge that releases cs_n.
//
// Ports:
//   clk, rst (async, active high)
//   start  in   begin a window (ignored by design only if owner never pulses
//               it mid-window)
//   cs_n   out  registered active-low select
//   done   out  last cycle of the window
// ---------------------------------------------------------------------------
module cs_pulse_gen #(
   parameter int CYCLES = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   output logic cs_n,
   output logic done
);

   localparam int CNT_W = $clog2(CYCLES + 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cs_n_q, cs_n_d;

   always_comb begin
      cnt_d  = cnt_q;
      cs_n_d = cs_n_q;
      if (start) begin
         cnt_d  = CNT_W'(CYCLES);
         cs_n_d = 1'b0;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) begin
            cs_n_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q  <= '0;
         cs_n_q <= 1'b1;
      end else begin
         cnt_q  <= cnt_d;
         cs_n_q <= cs_n_d;
      end
   end

   assign cs_n = cs_n_q;
   assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/cmd_ctrl_multi.sv
// ---------------------------------------------------------------------------
// cmd_ctrl_multi : byte-command controller for the analogue front end.
// Decodes UART command bytes, keeps one DAC code and NUM_POT pot codes with
// saturating inc/dec, opens a chip-select window after each code update,
// answers every accepted byte with one response byte, and shows the
// selected pot channel on a 7-segment digit.
//
// Ports:
//   clk  in  system clock
//   rst  in  asynchronous active-high reset (releases both cs_n at once)
//   bus  cmd_ctrl_multi_if.slave  (see interface file for signal list)
//
// Build option: CTRL_READBACK_EN adds readback commands 0x76 (selected pot
// code) and 0x77 (upper 8 bits of the DAC code); without it both are NAKed.
// ---------------------------------------------------------------------------
module cmd_ctrl_multi
   import ctrl_pkg::*;
#(
   parameter int                   NUM_POT       = 4,
   parameter int                   DAC_BITS      = 12,
   parameter logic [3:0]           DAC_CMD       = 4'hE,
   parameter int                   POT_BITS      = 8,
   parameter logic [DAC_BITS-1:0]  DAC_RST       = 12'h800,
   parameter logic [POT_BITS-1:0]  POT_RST       = 8'h80,
   parameter int                   DAC_CS_CYCLES = 68,
   parameter int                   POT_CS_CYCLES = 36
) (
   input logic              clk,
   input logic              rst,
   cmd_ctrl_multi_if.slave  bus
);

   localparam int SEL_W = $clog2(NUM_POT);

   ctrl_state_e         state_q, state_d;
   logic                rx_ready_q, rx_ready_d;
   logic [7:0]          resp_data_q, resp_data_d;
   logic                resp_valid_q, resp_valid_d;
   logic [DAC_BITS-1:0] dac_code_q, dac_code_d;
   logic [POT_BITS-1:0] pot_q [NUM_POT];
   logic [POT_BITS-1:0] pot_d [NUM_POT];
   logic [SEL_W-1:0]    sel_q, sel_d;
   logic [POT_BITS-1:0] pot_word_q, pot_word_d;
   logic [6:0]          seg_q, seg_d;

   logic dac_start, pot_start;
   logic dac_done, pot_done;
   logic dac_cs_n, pot_cs_n;
   logic accept;

   assign accept = bus.rx_valid && rx_ready_q;

   always_comb begin
      state_d      = state_q;
      resp_data_d  = resp_data_q;
      resp_valid_d = 1'b0;
      dac_code_d   = dac_code_q;
      pot_d        = pot_q;
      sel_d        = sel_q;
      dac_start    = 1'b0;
      pot_start    = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               resp_valid_d = 1'b1;
               case (bus.rx_data)
                  CMD_DAC_RST: begin
                     dac_code_d  = DAC_RST;
                     resp_data_d = RSP_DAC_RST;
                     dac_start   = 1'b1;
                     state_d     = DAC_FRAME;
                  end
                  CMD_DAC_INC: begin
                     // Saturated: code held, flag set, frame still sent.
                     if (dac_code_q == '1) begin
                        resp_data_d = RSP_DAC_INC | RSP_SAT_BIT;
                     end else begin
                        dac_code_d  = dac_code_q + 1'b1;
                        resp_data_d = RSP_DAC_INC;
                     end
                     dac_start = 1'b1;
                     state_d   = DAC_FRAME;
                  end
                  CMD_DAC_DEC: begin
                     if (dac_code_q == '0) begin
                        resp_data_d = RSP_DAC_DEC | RSP_SAT_BIT;
                     end else begin
                        dac_code_d  = dac_code_q - 1'b1;
                        resp_data_d = RSP_DAC_DEC;
                     end
                     dac_start = 1'b1;
                     state_d   = DAC_FRAME;
                  end
                  CMD_POT_RST: begin
                     pot_d[sel_q] = POT_RST;
                     resp_data_d  = RSP_POT_RST;
                     pot_start    = 1'b1;
                     state_d      = POT_FRAME;
                  end
                  CMD_POT_INC: begin
                     if (pot_q[sel_q] == '1) begin
                        resp_data_d = RSP_POT_INC | RSP_SAT_BIT;
                     end else begin
                        pot_d[sel_q] = pot_q[sel_q] + 1'b1;
                        resp_data_d  = RSP_POT_INC;
                     end
                     pot_start = 1'b1;
                     state_d   = POT_FRAME;
                  end
                  CMD_POT_DEC: begin
                     if (pot_q[sel_q] == '0) begin
                        resp_data_d = RSP_POT_DEC | RSP_SAT_BIT;
                     end else begin
                        pot_d[sel_q] = pot_q[sel_q] - 1'b1;
                        resp_data_d  = RSP_POT_DEC;
                     end
                     pot_start = 1'b1;
                     state_d   = POT_FRAME;
                  end
                  // Wrap is explicit so non-power-of-two channel counts work.
                  CMD_SEL_INC: begin
                     sel_d       = (sel_q == SEL_W'(NUM_POT - 1)) ? '0 : sel_q + 1'b1;
                     resp_data_d = RSP_SEL_INC;
                  end
                  CMD_SEL_DEC: begin
                     sel_d       = (sel_q == '0) ? SEL_W'(NUM_POT - 1) : sel_q - 1'b1;
                     resp_data_d = RSP_SEL_DEC;
                  end
`ifdef CTRL_READBACK_EN
                  CMD_RB_POT: begin
                     resp_data_d = 8'(pot_q[sel_q]);
                  end
                  CMD_RB_DAC: begin
                     resp_data_d = dac_code_q[DAC_BITS-1 -: 8];
                  end
`endif
                  default: begin
                     resp_data_d = RSP_NAK;
                  end
               endcase
            end
         end
         DAC_FRAME: begin
            if (dac_done) state_d = IDLE;
         end
         POT_FRAME: begin
            if (pot_done) state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Ready drops on the accept edge and returns on the edge that
      // releases cs_n, so it is low exactly across the window.
      rx_ready_d = (state_d == IDLE);
      pot_word_d = pot_d[sel_d];
      seg_d      = seg7_digit(4'(sel_d));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         rx_ready_q   <= 1'b1;
         resp_data_q  <= RSP_RESET;
         resp_valid_q <= 1'b0;
         dac_code_q   <= DAC_RST;
         for (int i = 0; i < NUM_POT; i++) begin
            pot_q[i] <= POT_RST;
         end
         sel_q        <= '0;
         pot_word_q   <= POT_RST;
         seg_q        <= 7'b1000000;
      end else begin
         state_q      <= state_d;
         rx_ready_q   <= rx_ready_d;
         resp_data_q  <= resp_data_d;
         resp_valid_q <= resp_valid_d;
         dac_code_q   <= dac_code_d;
         pot_q        <= pot_d;
         sel_q        <= sel_d;
         pot_word_q   <= pot_word_d;
         seg_q        <= seg_d;
      end
   end

   cs_pulse_gen #(.CYCLES(DAC_CS_CYCLES)) u_dac_cs (
      .clk   (clk),
      .rst   (rst),
      .start (dac_start),
      .cs_n  (dac_cs_n),
      .done  (dac_done)
   );

   cs_pulse_gen #(.CYCLES(POT_CS_CYCLES)) u_pot_cs (
      .clk   (clk),
      .rst   (rst),
      .start (pot_start),
      .cs_n  (pot_cs_n),
      .done  (pot_done)
   );

   assign bus.rx_ready   = rx_ready_q;
   assign bus.resp_data  = resp_data_q;
   assign bus.resp_valid = resp_valid_q;
   assign bus.dac_word   = {DAC_CMD, dac_code_q};
   assign bus.dac_cs_n   = dac_cs_n;
   assign bus.pot_sel    = sel_q;
   assign bus.pot_word   = pot_word_q;
   assign bus.pot_cs_n   = pot_cs_n;
   assign bus.seg        = seg_q;
   assign bus.state      = state_q;

endmodule

// File: tb/tb_cmd_ctrl_multi.sv
// ---------------------------------------------------------------------------
// tb_cmd_ctrl_multi : directed bench for cmd_ctrl_multi.
// dut  : default parameters (4 channels, 68/36-cycle windows).
// dut2 : 3 channels, DAC reset code 0, short windows -- reaches the DAC
//        low boundary and the non-power-of-two select wrap quickly.
// ---------------------------------------------------------------------------
module tb_cmd_ctrl_multi;
   import ctrl_pkg::*;

   logic clk;
   logic rst;

   int n_cmp;
   int n_err;

   cmd_ctrl_multi_if #(.SEL_W(2), .DAC_BITS(12), .POT_BITS(8)) bus ();
   cmd_ctrl_multi_if #(.SEL_W(2), .DAC_BITS(12), .POT_BITS(8)) bus2 ();

   cmd_ctrl_multi dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   cmd_ctrl_multi #(
      .NUM_POT       (3),
      .DAC_RST       (12'h000),
      .DAC_CS_CYCLES (3),
      .POT_CS_CYCLES (2)
   ) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2.slave)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checker ----------------
   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Send one byte to dut, check the response in cycle k+1, then measure
   // the cs_n windows and the rx_ready-low span until the unit is idle.
   task automatic do_cmd(input string tag, input logic [7:0] cmd, input logic [7:0] exp_rsp,
                         input int exp_dac, input int exp_pot);
      int n_dac;
      int n_pot;
      int n_nrdy;
      int guard;
      n_dac  = 0;
      n_pot  = 0;
      n_nrdy = 0;
      guard  = 0;
      @(negedge clk);
      bus.rx_data  = cmd;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      check_val({tag, "_rvalid"}, 32'(bus.resp_valid), 32'd1);
      check_val({tag, "_rdata"}, 32'(bus.resp_data), 32'(exp_rsp));
      while (!(bus.dac_cs_n && bus.pot_cs_n && bus.rx_ready) && guard < 400) begin
         if (!bus.dac_cs_n) n_dac++;
         if (!bus.pot_cs_n) n_pot++;
         if (!bus.rx_ready) n_nrdy++;
         @(negedge clk);
         guard++;
      end
      if (guard == 0) @(negedge clk);
      check_val({tag, "_timeout"}, 32'(guard < 400), 32'd1);
      check_val({tag, "_dac_cs_len"}, 32'(n_dac), 32'(exp_dac));
      check_val({tag, "_pot_cs_len"}, 32'(n_pot), 32'(exp_pot));
      check_val({tag, "_nrdy_len"}, 32'(n_nrdy), 32'(exp_dac + exp_pot));
      check_val({tag, "_rvalid_off"}, 32'(bus.resp_valid), 32'd0);
   endtask

   task automatic send2(input string tag, input logic [7:0] cmd, input logic [7:0] exp_rsp);
      @(negedge clk);
      bus2.rx_data  = cmd;
      bus2.rx_valid = 1'b1;
      @(negedge clk);
      bus2.rx_valid = 1'b0;
      check_val({tag, "_rvalid"}, 32'(bus2.resp_valid), 32'd1);
      check_val({tag, "_rdata"}, 32'(bus2.resp_data), 32'(exp_rsp));
      repeat (5) @(negedge clk);
      check_val({tag, "_ready"}, 32'(bus2.rx_ready), 32'd1);
   endtask

   // ---------------- scoreboard (expected pot codes of dut) ----------------
   logic [7:0] exp_q[$];

   // ---------------- main sequence ----------------
   initial begin
      int guard;
      n_cmp = 0;
      n_err = 0;
      bus.rx_data   = 8'h00;
      bus.rx_valid  = 1'b0;
      bus2.rx_data  = 8'h00;
      bus2.rx_valid = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset values
      check_val("rst_dac_word", 32'(bus.dac_word), 32'h0000_E800);
      check_val("rst_dac_cs_n", 32'(bus.dac_cs_n), 32'd1);
      check_val("rst_pot_cs_n", 32'(bus.pot_cs_n), 32'd1);
      check_val("rst_pot_sel", 32'(bus.pot_sel), 32'd0);
      check_val("rst_pot_word", 32'(bus.pot_word), 32'h80);
      check_val("rst_seg", 32'(bus.seg), 32'h40);
      check_val("rst_resp_data", 32'(bus.resp_data), 32'h40);
      check_val("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
      check_val("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
      check_val("rst_state", 32'(bus.state), 32'(IDLE));

      // DAC increment
      do_cmd("dac_inc", 8'h74, 8'h03, 68, 0);
      check_val("dac_inc_word", 32'(bus.dac_word), 32'h0000_E801);

      // Pot increments on channel 0, then move to channel 1 and decrement
      for (int i = 0; i < 3; i++) do_cmd("pot_inc", 8'h67, 8'h06, 0, 36);
      check_val("pot0_word", 32'(bus.pot_word), 32'h83);
      do_cmd("sel_inc", 8'h61, 8'h08, 0, 0);
      check_val("sel1_sel", 32'(bus.pot_sel), 32'd1);
      check_val("sel1_seg", 32'(bus.seg), 32'h79);
      check_val("sel1_word", 32'(bus.pot_word), 32'h80);
      do_cmd("pot_dec", 8'h64, 8'h07, 0, 36);
      check_val("pot1_word", 32'(bus.pot_word), 32'h7F);

`ifdef CTRL_READBACK_EN
      do_cmd("rb_pot", 8'h76, 8'h7F, 0, 0);
      do_cmd("rb_dac", 8'h77, 8'h80, 0, 0);
`else
      do_cmd("rb_pot", 8'h76, 8'h3F, 0, 0);
      do_cmd("rb_dac", 8'h77, 8'h3F, 0, 0);
`endif

      do_cmd("sel_dec", 8'h71, 8'h09, 0, 0);
      check_val("sel0_sel", 32'(bus.pot_sel), 32'd0);
      check_val("sel0_word", 32'(bus.pot_word), 32'h83);

      // Select wrap both ways
      do_cmd("sel_wrap_dn", 8'h71, 8'h09, 0, 0);
      check_val("wrap_dn_sel", 32'(bus.pot_sel), 32'd3);
      check_val("wrap_dn_seg", 32'(bus.seg), 32'h30);
      check_val("wrap_dn_word", 32'(bus.pot_word), 32'h80);
      do_cmd("sel_wrap_up", 8'h61, 8'h08, 0, 0);
      check_val("wrap_up_sel", 32'(bus.pot_sel), 32'd0);
      check_val("wrap_up_seg", 32'(bus.seg), 32'h40);

      // Drive pot[0] from 0x83 to 0xFF; each expected code queued first
      for (int v = 8'h84; v <= 8'hFF; v++) exp_q.push_back(8'(v));
      while (exp_q.size() > 0) begin
         logic [7:0] e;
         e = exp_q.pop_front();
         do_cmd("pot_climb", 8'h67, 8'h06, 0, 36);
         check_val("pot_climb_word", 32'(bus.pot_word), 32'(e));
      end
      do_cmd("pot_sat", 8'h67, 8'h86, 0, 36);
      check_val("pot_sat_word", 32'(bus.pot_word), 32'hFF);
      do_cmd("pot_after_sat", 8'h64, 8'h07, 0, 36);
      check_val("pot_after_sat_word", 32'(bus.pot_word), 32'hFE);
      do_cmd("peek_ch1", 8'h61, 8'h08, 0, 0);
      check_val("ch1_untouched", 32'(bus.pot_word), 32'h7F);
      do_cmd("back_ch0", 8'h71, 8'h09, 0, 0);

      // Byte offered during cycle k+1 of a frame is dropped
      @(negedge clk);
      bus.rx_data  = 8'h74;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      check_val("drop_first_rdata", 32'(bus.resp_data), 32'h03);
      check_val("drop_first_ready", 32'(bus.rx_ready), 32'd0);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      check_val("drop_no_resp", 32'(bus.resp_valid), 32'd0);
      guard = 0;
      while (!bus.rx_ready && guard < 200) begin
         @(negedge clk);
         guard++;
      end
      check_val("drop_timeout", 32'(guard < 200), 32'd1);
      check_val("drop_dac_word", 32'(bus.dac_word), 32'h0000_E802);
      do_cmd("nak", 8'h55, 8'h3F, 0, 0);
      check_val("nak_dac_word", 32'(bus.dac_word), 32'h0000_E802);

      // Reset during a DAC frame
      @(negedge clk);
      bus.rx_data  = 8'h74;
      bus.rx_valid = 1'b1;
      @(negedge clk);
      bus.rx_valid = 1'b0;
      check_val("midrst_cs_c1", 32'(bus.dac_cs_n), 32'd0);
      repeat (19) @(negedge clk);
      check_val("midrst_cs_c20", 32'(bus.dac_cs_n), 32'd0);
      #1 rst = 1'b1;
      #1;
      check_val("midrst_cs_async", 32'(bus.dac_cs_n), 32'd1);
      check_val("midrst_ready_async", 32'(bus.rx_ready), 32'd1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_val("postrst_dac_word", 32'(bus.dac_word), 32'h0000_E800);
      check_val("postrst_ready", 32'(bus.rx_ready), 32'd1);
      check_val("postrst_pot_word", 32'(bus.pot_word), 32'h80);
      check_val("postrst_dac_cs", 32'(bus.dac_cs_n), 32'd1);

      // dut2: DAC low boundary, 3-channel select wrap
      check_val("d2_rst_word", 32'(bus2.dac_word), 32'h0000_E000);
      send2("d2_dac_dec_sat", 8'h65, 8'h84);
      check_val("d2_sat_word", 32'(bus2.dac_word), 32'h0000_E000);
      send2("d2_dac_inc", 8'h74, 8'h03);
      check_val("d2_inc_word", 32'(bus2.dac_word), 32'h0000_E001);
      send2("d2_sel_dec", 8'h71, 8'h09);
      check_val("d2_wrap_sel", 32'(bus2.pot_sel), 32'd2);
      check_val("d2_wrap_seg", 32'(bus2.seg), 32'h24);
      send2("d2_sel_inc", 8'h61, 8'h08);
      check_val("d2_wrap_up_sel", 32'(bus2.pot_sel), 32'd0);
      check_val("d2_wrap_up_seg", 32'(bus2.seg), 32'h40);
      send2("d2_sel_dec2", 8'h71, 8'h09);
      send2("d2_sel_dec3", 8'h71, 8'h09);
      check_val("d2_sel1", 32'(bus2.pot_sel), 32'd1);
      check_val("d2_seg1", 32'(bus2.seg), 32'h79);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
